// File: rtl/aes_round_engine_if.sv
// -----------------------------------------------------------------------------
// aes_round_engine_if
//   Bundles the block-input handshake, the round-key fetch port, the result
//   handshake and the flush/busy control of aes_round_engine.
//
//   Handshake rule (both sides): a transfer happens on a rising clock edge where
//   valid and ready are both 1. The producer holds valid and its data stable
//   until that edge; ready may change freely and never depends on valid.
//
//   Signals (direction seen from the engine, i.e. the slave modport):
//     in_valid, mode_in, text_0_in..text_3_in   in   block offered by upstream
//     in_ready                                  out  engine can accept a block
//     flush                                     in   synchronous abort
//     rk_idx                                    out  round key index wanted now
//     rk_0_in..rk_3_in                          in   round key words for rk_idx
//     out_valid, text_0_out..text_3_out         out  result block
//     out_ready                                 in   downstream takes result
//     busy                                      out  engine is ROUND or DONE
// -----------------------------------------------------------------------------
interface aes_round_engine_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  mode_in;
    logic [DATA_WIDTH-1:0] text_0_in;
    logic [DATA_WIDTH-1:0] text_1_in;
    logic [DATA_WIDTH-1:0] text_2_in;
    logic [DATA_WIDTH-1:0] text_3_in;
    logic                  flush;
    logic [3:0]            rk_idx;
    logic [DATA_WIDTH-1:0] rk_0_in;
    logic [DATA_WIDTH-1:0] rk_1_in;
    logic [DATA_WIDTH-1:0] rk_2_in;
    logic [DATA_WIDTH-1:0] rk_3_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] text_0_out;
    logic [DATA_WIDTH-1:0] text_1_out;
    logic [DATA_WIDTH-1:0] text_2_out;
    logic [DATA_WIDTH-1:0] text_3_out;
    logic                  busy;

    // Environment side: upstream staging, key store and output formatter.
    modport master (
        output in_valid, mode_in, text_0_in, text_1_in, text_2_in, text_3_in,
        output flush, rk_0_in, rk_1_in, rk_2_in, rk_3_in, out_ready,
        input  in_ready, rk_idx, out_valid, busy,
        input  text_0_out, text_1_out, text_2_out, text_3_out
    );

    // Engine side.
    modport slave (
        input  in_valid, mode_in, text_0_in, text_1_in, text_2_in, text_3_in,
        input  flush, rk_0_in, rk_1_in, rk_2_in, rk_3_in, out_ready,
        output in_ready, rk_idx, out_valid, busy,
        output text_0_out, text_1_out, text_2_out, text_3_out
    );
endinterface

// File: rtl/aes_round_engine.sv
// -----------------------------------------------------------------------------
// aes_round_engine
//   Iterative AES-128/192/256 round engine, one round per clock, encrypt or
//   decrypt chosen per block. Round keys are fetched by index from an external
//   key-expansion store that answers combinationally in the same cycle.
//
//   Ports:
//     clk          in   clock
//     rst_n        in   asynchronous active-low reset
//     bus          slave modport of aes_round_engine_if (handshakes, key port,
//                  flush, busy)
//     o_dbg_state  out  current FSM state (0 IDLE, 1 ROUND, 2 DONE)
//
//   State layout: 128-bit vector {word0, word1, word2, word3}; word c is
//   column c with row 0 in its MSB byte, so byte k = 4*c + r sits at
//   bits [127-8k -: 8] (FIPS-197 input byte order).
// -----------------------------------------------------------------------------
module aes_round_engine #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_ROUNDS     = 10,
    parameter bit ENABLE_DECRYPT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_round_engine_if.slave  bus,
    output logic [1:0]         o_dbg_state
);

    localparam logic [3:0] NR = 4'(NUM_ROUNDS);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // ---------------------------------------------------------------- helpers
    function automatic logic [7:0] sbox_lu(input logic [7:0] b, input logic inv);
        int idx;
        idx = 2047 - 8 * int'(b);
        return inv ? INV_SBOX[idx -: 8] : SBOX[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant as a sum of a, 2a, 4a, 8a.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = sbox_lu(s[8*i +: 8], inv);
        end
        return o;
    endfunction

    // Row r rotates left by r columns (right by r for the inverse).
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*src + r) -: 8];
            end
        end
        return o;
    endfunction

    // Circulant matrix whose first row is {2,3,1,1} or {e,b,d,9}.
    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [15:0]  coef;
        logic [7:0]   acc;
        logic [3:0]   m;
        coef = inv ? 16'hebd9 : 16'h2311;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    m   = coef[15 - 4*((j - r + 4) % 4) -: 4];
                    acc = acc ^ gf_mul(s[127 - 8*(4*c + j) -: 8], m);
                end
                o[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    // ------------------------------------------------------------- registers
    state_t       r_state, w_state_nxt;
    logic [127:0] r_data,  w_data_nxt;
    logic [3:0]   r_cnt,   w_cnt_nxt;
    logic         r_mode,  w_mode_nxt;

    logic [127:0] w_rk;
    logic [127:0] w_text_in;
    logic [127:0] w_enc_sr;
    logic [127:0] w_enc_out;
    logic [127:0] w_dec_out;
    logic [127:0] w_round_out;
    logic         w_mode_in;
    logic         w_out_valid;

    assign w_rk      = {bus.rk_0_in, bus.rk_1_in, bus.rk_2_in, bus.rk_3_in};
    assign w_text_in = {bus.text_0_in, bus.text_1_in, bus.text_2_in, bus.text_3_in};

    // ------------------------------------------------------- round datapath
    assign w_enc_sr  = shift_rows(sub_bytes(r_data, 1'b0), 1'b0);
    assign w_enc_out = (r_cnt == 4'd0) ? (r_data ^ w_rk) :
                       (r_cnt == NR)   ? (w_enc_sr ^ w_rk) :
                                         (mix_columns(w_enc_sr, 1'b0) ^ w_rk);

    generate
        if (ENABLE_DECRYPT) begin : g_dec
            logic [127:0] w_dec_ark;
            assign w_dec_ark = sub_bytes(shift_rows(r_data, 1'b1), 1'b1) ^ w_rk;
            // Key is added before InvMixColumns, so rounds 1..Nr-1 fetch keys
            // in the plain reverse schedule order.
            assign w_dec_out = (r_cnt == 4'd0) ? (r_data ^ w_rk) :
                               (r_cnt == NR)   ? w_dec_ark :
                                                 mix_columns(w_dec_ark, 1'b1);
            assign w_mode_in = bus.mode_in;
        end else begin : g_no_dec
            assign w_dec_out = '0;
            assign w_mode_in = 1'b0;
        end
    endgenerate

    assign w_round_out = r_mode ? w_dec_out : w_enc_out;

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_data_nxt  = w_text_in;
                    w_mode_nxt  = w_mode_in;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                w_data_nxt = w_round_out;
                if (r_cnt == NR) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Flush overrides everything, including a coinciding accept or delivery.
        if (bus.flush) begin
            w_state_nxt = S_IDLE;
            w_data_nxt  = '0;
            w_cnt_nxt   = 4'd0;
            w_mode_nxt  = 1'b0;
        end
    end

    // --------------------------------------------------------------- outputs
    assign w_out_valid    = (r_state == S_DONE);
    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.out_valid  = w_out_valid;
    assign bus.busy       = (r_state == S_ROUND) || (r_state == S_DONE);
    assign bus.rk_idx     = (r_state != S_ROUND) ? 4'd0 :
                            (r_mode ? (NR - r_cnt) : r_cnt);
    assign bus.text_0_out = w_out_valid ? r_data[127:96] : '0;
    assign bus.text_1_out = w_out_valid ? r_data[95:64]  : '0;
    assign bus.text_2_out = w_out_valid ? r_data[63:32]  : '0;
    assign bus.text_3_out = w_out_valid ? r_data[31:0]   : '0;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_aes_round_engine.sv
// -----------------------------------------------------------------------------
// tb_aes_round_engine
//   Three engines (Nr = 10, 12, 14) share clock and reset. The bench builds its
//   own S-box from GF(2^8) inversion plus the affine map, expands the FIPS-197
//   keys into per-engine key stores, drives FIPS-197 C.1/C.2/C.3 vectors and
//   checks results through an expected queue drained by a monitor.
// -----------------------------------------------------------------------------
module tb_aes_round_engine;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    // ------------------------------------------------------ clock and reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ------------------------------------------------------------ DUT wiring
    logic [2:0]        in_valid_v  = '0;
    logic [2:0]        mode_v      = '0;
    logic [2:0]        flush_v     = '0;
    logic [2:0]        out_ready_v = '1;
    logic [2:0][127:0] text_v      = '0;
    logic [2:0]        in_ready_v;
    logic [2:0]        out_valid_v;
    logic [2:0]        busy_v;
    logic [2:0][3:0]   rk_idx_v;
    logic [2:0][127:0] out_text_v;
    logic [2:0][1:0]   dbg_state_v;
    logic [31:0]       rk_tab [3][64];
    logic [7:0]        sbox_t [256];

    for (genvar g = 0; g < 3; g++) begin : g_eng
        aes_round_engine_if #(.DATA_WIDTH(32)) u_if ();

        assign u_if.in_valid  = in_valid_v[g];
        assign u_if.mode_in   = mode_v[g];
        assign u_if.text_0_in = text_v[g][127:96];
        assign u_if.text_1_in = text_v[g][95:64];
        assign u_if.text_2_in = text_v[g][63:32];
        assign u_if.text_3_in = text_v[g][31:0];
        assign u_if.flush     = flush_v[g];
        assign u_if.out_ready = out_ready_v[g];
        assign u_if.rk_0_in   = rk_tab[g][{u_if.rk_idx, 2'b00}];
        assign u_if.rk_1_in   = rk_tab[g][{u_if.rk_idx, 2'b01}];
        assign u_if.rk_2_in   = rk_tab[g][{u_if.rk_idx, 2'b10}];
        assign u_if.rk_3_in   = rk_tab[g][{u_if.rk_idx, 2'b11}];

        assign in_ready_v[g]  = u_if.in_ready;
        assign out_valid_v[g] = u_if.out_valid;
        assign busy_v[g]      = u_if.busy;
        assign rk_idx_v[g]    = u_if.rk_idx;
        assign out_text_v[g]  = {u_if.text_0_out, u_if.text_1_out,
                                 u_if.text_2_out, u_if.text_3_out};

        aes_round_engine #(
            .DATA_WIDTH    (32),
            .NUM_ROUNDS    (10 + 2*g),
            .ENABLE_DECRYPT(1'b1)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .bus        (u_if),
            .o_dbg_state(dbg_state_v[g])
        );
    end

    // ------------------------------------------------------------ scoreboard
    logic [127:0] exp_q[$];
    int           exp_lat_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           acc_cyc  = 0;
    logic [2:0]   prev_valid = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s actual=timeout required=event cyc=%0d", name, cyc);
    endtask

    // Monitor samples mid low phase, after the driver has settled its inputs.
    always @(negedge clk) begin
        #3;
        for (int g = 0; g < 3; g++) begin
            if (out_valid_v[g] && !prev_valid[g]) begin
                if (exp_lat_q.size() == 0) begin
                    fail_now($sformatf("unexpected_valid_eng%0d", g));
                end else begin
                    check($sformatf("latency_eng%0d", g), 128'(cyc - acc_cyc),
                          128'(exp_lat_q.pop_front()));
                end
            end
            if (out_valid_v[g] && out_ready_v[g]) begin
                if (exp_q.size() == 0) begin
                    fail_now($sformatf("unexpected_result_eng%0d", g));
                end else begin
                    check($sformatf("result_eng%0d", g), out_text_v[g], exp_q.pop_front());
                end
            end
            prev_valid[g] = out_valid_v[g];
        end
    end

    // ------------------------------------------------------------- key model
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                        rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input int g, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          total;
        total = 4 * (nk + 7);
        rc    = 8'h01;
        for (int i = 0; i < 64; i++) rk_tab[g][i] = 32'h0;
        for (int i = 0; i < total; i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            rk_tab[g][i] = w[i];
        end
    endtask

    // --------------------------------------------------------------- drivers
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int g);
        int guard;
        guard = 0;
        while (!in_ready_v[g] && guard < 200) begin
            tick();
            guard++;
        end
        if (!in_ready_v[g]) fail_now($sformatf("idle_timeout_eng%0d", g));
    endtask

    task automatic wait_valid(input int g);
        int guard;
        guard = 0;
        while (!out_valid_v[g] && guard < 200) begin
            tick();
            guard++;
        end
        if (!out_valid_v[g]) fail_now($sformatf("valid_timeout_eng%0d", g));
    endtask

    task automatic check_reset_outputs(input int g, input string tag);
        check($sformatf("%s_in_ready%0d", tag, g),  128'(in_ready_v[g]),  128'(1));
        check($sformatf("%s_out_valid%0d", tag, g), 128'(out_valid_v[g]), 128'(0));
        check($sformatf("%s_busy%0d", tag, g),      128'(busy_v[g]),      128'(0));
        check($sformatf("%s_rk_idx%0d", tag, g),    128'(rk_idx_v[g]),    128'(0));
        check($sformatf("%s_text%0d", tag, g),      out_text_v[g],        128'(0));
    endtask

    // Offer one block; optionally queue its expected result and walk the
    // round-key index sequence while the rounds run.
    task automatic send(input int g, input logic mode, input logic [127:0] txt,
                        input logic [127:0] exp, input bit push, input bit chk_rk);
        int nr;
        nr = 10 + 2*g;
        wait_idle(g);
        in_valid_v[g] = 1'b1;
        mode_v[g]     = mode;
        text_v[g]     = txt;
        tick();
        acc_cyc       = cyc;
        in_valid_v[g] = 1'b0;
        text_v[g]     = '0;
        if (push) begin
            exp_q.push_back(exp);
            exp_lat_q.push_back(nr + 1);
        end
        if (chk_rk) begin
            check($sformatf("in_ready_low_eng%0d", g), 128'(in_ready_v[g]), 128'(0));
            check($sformatf("busy_high_eng%0d", g),    128'(busy_v[g]),     128'(1));
            for (int k = 0; k <= nr; k++) begin
                check($sformatf("rk_idx_eng%0d_m%0d_k%0d", g, mode, k),
                      128'(rk_idx_v[g]), 128'(mode ? nr - k : k));
                tick();
            end
        end
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        rst_n = 1'b0;
        build_sbox();
        expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        expand(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
        expand(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

        repeat (3) tick();
        for (int g = 0; g < 3; g++) check_reset_outputs(g, "reset");
        rst_n = 1'b1;
        tick();

        // Known-answer blocks, both directions, all key sizes.
        send(0, 1'b0, PT,  CT1, 1'b1, 1'b1);
        wait_idle(0);
        send(0, 1'b1, CT1, PT,  1'b1, 1'b1);
        wait_idle(0);
        send(1, 1'b0, PT,  CT2, 1'b1, 1'b1);
        wait_idle(1);
        send(1, 1'b1, CT2, PT,  1'b1, 1'b1);
        wait_idle(1);
        send(2, 1'b0, PT,  CT3, 1'b1, 1'b1);
        wait_idle(2);
        send(2, 1'b1, CT3, PT,  1'b1, 1'b1);
        wait_idle(2);

        // Back-pressure: result must sit still for 20 cycles.
        out_ready_v[0] = 1'b0;
        send(0, 1'b0, PT, CT1, 1'b1, 1'b0);
        wait_valid(0);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("bp_valid_%0d", i),    128'(out_valid_v[0]), 128'(1));
            check($sformatf("bp_data_%0d", i),     out_text_v[0],        CT1);
            check($sformatf("bp_in_ready_%0d", i), 128'(in_ready_v[0]),  128'(0));
            tick();
        end
        out_ready_v[0] = 1'b1;
        tick();
        check("release_in_ready",  128'(in_ready_v[0]),  128'(1));
        check("release_out_valid", 128'(out_valid_v[0]), 128'(0));
        send(0, 1'b1, CT1, PT, 1'b1, 1'b0);
        wait_idle(0);

        // Flush coinciding with an accept drops the block.
        flush_v[0]    = 1'b1;
        in_valid_v[0] = 1'b1;
        text_v[0]     = PT;
        tick();
        flush_v[0]    = 1'b0;
        in_valid_v[0] = 1'b0;
        check("flush_accept_in_ready", 128'(in_ready_v[0]), 128'(1));
        check("flush_accept_busy",     128'(busy_v[0]),     128'(0));

        // Flush at cnt=5: no result may ever appear for that block.
        send(0, 1'b0, PT, CT1, 1'b0, 1'b0);
        repeat (5) tick();
        check("pre_flush_busy", 128'(busy_v[0]), 128'(1));
        flush_v[0] = 1'b1;
        tick();
        flush_v[0] = 1'b0;
        check("flush_in_ready",  128'(in_ready_v[0]),  128'(1));
        check("flush_out_valid", 128'(out_valid_v[0]), 128'(0));
        check("flush_busy",      128'(busy_v[0]),      128'(0));
        repeat (15) tick();
        send(0, 1'b0, PT, CT1, 1'b1, 1'b1);
        wait_idle(0);

        // Reset at cnt=3 held for two cycles.
        send(0, 1'b0, PT, CT1, 1'b0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check_reset_outputs(0, "midrst_a");
        tick();
        check_reset_outputs(0, "midrst_b");
        rst_n = 1'b1;
        tick();
        send(0, 1'b0, PT, CT1, 1'b1, 1'b1);
        wait_idle(0);

        // Every queued expectation must have been consumed.
        for (int i = 0; i < 50 && (exp_q.size() != 0 || exp_lat_q.size() != 0); i++) tick();
        check("queue_drained", 128'(exp_q.size() + exp_lat_q.size()), 128'(0));
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_round_engine.md
Name: aes_round_engine

Overview:
Iterative AES round engine for AES-128/192/256 with encrypt and decrypt modes.
- Owns its round sequencing (internal FSM and round counter); it takes no external core state or count.
- Fetches round keys by index from the external key-expansion store.
- Sits between the block-input staging logic and the output formatter. Uses valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 32, word width; only 32 is legal; the state is 4 words, word0 = column 0, MSB byte = row 0.
- NUM_ROUNDS, 10, number of AES rounds Nr; legal values 10, 12, 14.
- ENABLE_DECRYPT, 1, when 1 the inverse cipher datapath is built; when 0, mode_in is ignored and encryption is always used.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  input block valid
- in_ready  output  1  engine can accept a block
- mode_in  input  1  0 = encrypt, 1 = decrypt; sampled on accept
- text_0_in..text_3_in  input  DATA_WIDTH each  input state words
- flush  input  1  synchronous abort
- rk_idx  output  4  round key index requested this cycle
- rk_0_in..rk_3_in  input  DATA_WIDTH each  round key words for rk_idx, combinational same-cycle return
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- text_0_out..text_3_out  output  DATA_WIDTH each  result words; 0 when out_valid=0
- busy  output  1  state is ROUND or DONE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; state words, counter and mode register clear to 0.
  - Outputs during and after reset: in_ready=1, out_valid=0, busy=0, rk_idx=0, text_*_out=0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs on in_valid&in_ready: latch text_*_in into the state registers, latch the mode, clear cnt to 0, go to ROUND.
- ROUND:
  - One round per cycle; cnt runs 0..NUM_ROUNDS.
  - rk_idx = cnt for encrypt, NUM_ROUNDS-cnt for decrypt.
  - Encrypt round operations:
    - cnt=0: state ^= rk.
    - 1..Nr-1: SubBytes, ShiftRows, MixColumns, then ^rk.
    - cnt=Nr: SubBytes, ShiftRows, then ^rk.
  - Decrypt round operations:
    - cnt=0: state ^= rk.
    - 1..Nr-1: InvShiftRows, InvSubBytes, ^rk, then InvMixColumns.
    - cnt=Nr: InvShiftRows, InvSubBytes, then ^rk.
  - When the cnt=Nr result is registered, go to DONE.
- DONE:
  - out_valid=1; text_*_out = state registers.
  - Result words are held stable while out_ready=0.
  - On out_ready=1, return to IDLE.
- Latency and throughput:
  - out_valid rises Nr+1 rising edges after the accept edge (11 for AES-128).
  - in_ready is high only in IDLE.
  - Minimum block interval is Nr+3 cycles with out_ready held at 1.
- rk_idx in IDLE and DONE is 0 and must not affect state.
- flush:
  - In any state, flush=1 forces IDLE on the next edge, clears out_valid, and clears the state registers.
  - If flush and accept coincide, flush wins and the block is dropped.
  - If flush and out_ready coincide in DONE, the result counts as not delivered.
- Reset mid-operation: immediate return to IDLE with outputs as in reset. No partial result is ever presented.
- in_valid and text_*_in are ignored while not in IDLE. Upstream holds them until in_ready.
- All XOR, S-box and GF(2^8) arithmetic is byte-wise, no carries. MixColumns uses xtime with reduction polynomial 0x11B.
- ENABLE_DECRYPT=0: no inverse logic is generated; rk_idx always equals cnt.

Test Plan:
- FIPS-197 C.1, NUM_ROUNDS=10, encrypt:
  - Stimulus: pt 00112233445566778899aabbccddeeff; bench key model supplies the expansion of key 000102030405060708090a0b0c0d0e0f.
  - Required: out = 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 11 edges after accept; rk_idx sequence 0..10.
- Same key, decrypt:
  - Stimulus: in 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: out 00112233445566778899aabbccddeeff; rk_idx sequence 10..0.
- NUM_ROUNDS=12 and 14 builds:
  - Stimulus: FIPS C.2 and C.3 plaintext and keys.
  - Required: dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089; latency 13 and 15 edges.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 20 cycles in DONE.
  - Required: out_valid and data stable, in_ready=0; release leads to IDLE next edge, and a second back-to-back block completes correctly.
- flush at cnt=5, then a new C.1 block:
  - Required: out_valid never asserts for the flushed block; the new block yields 69c4e0d8....
- rst_n low at cnt=3 for 2 cycles, then a new block:
  - Required: all outputs are reset values during reset; the next block gives the correct ciphertext.
